pkt_capture: RTL and testbench

Ingress stage directly upstream of the Avalon-MM packet writer: accepts the MAC's 32-bit Avalon-ST receive stream, pushes packet words into the shared 512-word packet FIFO, and latches the SOP timestamp. On EOP it hands one packet descriptor (begin/end offsets, ring write address, timestamp) to the writer with a one-cycle `wr_ctrl` pulse and waits for `wr_ctrl_rdy`. It also manages the DMA ring write pointer with wrap-around, and drops packets when no space is available.

---
 rtl/tcpdump_pkg.sv | 31 +++
 rtl/ring_addr_gen.sv | 38 +++
 rtl/pkt_capture.sv | 204 ++++++++++++++++++++
 tb/tb_pkt_capture.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tcpdump_pkg.sv
// Shared types and constants for the capture path and the packet writer.
package tcpdump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DROP,
    ANNOUNCE,
    WAIT_DONE
  } cap_state_t;

  localparam logic [31:0] TS_HDR_BYTES = 32'd16;
  localparam logic [31:0] REC_ALIGN    = 32'd16;
  localparam int DEFAULT_MAX_PKT_WORDS = 380;

  // Descriptor handed to the writer for each announced packet.
  typedef struct packed {
    logic [31:0] pktBegin;
    logic [31:0] pktEnd;
    logic [31:0] address;
    logic [31:0] tsSec;
    logic [31:0] tsNs;
    logic [31:0] ctrl;
  } pkt_desc_t;

  // Ring record size: timestamp header plus payload, padded to the record alignment.
  function automatic logic [31:0] recordBytes(input logic [31:0] lenBytes);
    recordBytes = (lenBytes + TS_HDR_BYTES + REC_ALIGN - 32'd1) & ~(REC_ALIGN - 32'd1);
  endfunction

endpackage

// File: rtl/ring_addr_gen.sv
// Owns the capture ring write pointer. The record placement (wrap back to the
// ring base when the record would run past the end) is combinational from the
// pending length, and the pointer moves past the record on a commit strobe.
module ring_addr_gen #(
  parameter logic [31:0] RING_BASE = 32'h0000_0000,
  parameter logic [31:0] RING_SIZE = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_length,
  input  logic        i_commit,
  output logic [31:0] o_address
);
  import tcpdump_pkg::*;

  logic [31:0] r_wrPtr;
  logic [31:0] w_record;
  logic [32:0] w_recEnd;
  logic [32:0] w_ringEnd;

  // Record size and wrap decision; 33-bit sums so the compare cannot overflow.
  always_comb begin
    w_record  = recordBytes(i_length);
    w_recEnd  = {1'b0, r_wrPtr} + {1'b0, w_record};
    w_ringEnd = {1'b0, RING_BASE} + {1'b0, RING_SIZE};
    o_address = (w_recEnd > w_ringEnd) ? RING_BASE : r_wrPtr;
  end

  // Advance the write pointer past the committed record.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= RING_BASE;
    end else if (i_commit) begin
      r_wrPtr <= o_address + w_record;
    end
  end

endmodule

// File: rtl/pkt_capture.sv
// Ingress capture stage: writes admitted Avalon-ST packets into the packet FIFO,
// then announces one descriptor per packet to the writer and waits for it to finish.
module pkt_capture #(
  parameter logic [31:0] RING_BASE     = 32'h0000_0000,
  parameter logic [31:0] RING_SIZE     = 32'h0010_0000,
  parameter int          MAX_PKT_WORDS = tcpdump_pkg::DEFAULT_MAX_PKT_WORDS,
  parameter int          FIFO_DEPTH    = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] st_data,
  input  logic        st_valid,
  input  logic        st_sop,
  input  logic        st_eop,
  input  logic [1:0]  st_empty,
  input  logic        st_error,
  output logic        st_ready,
  input  logic [31:0] control,
  input  logic [31:0] seconds,
  input  logic [31:0] nanoseconds,
  output logic [31:0] fifo_data,
  output logic        fifo_wrreq,
  input  logic [8:0]  fifo_usedw,
  input  logic        fifo_full,
  output logic        wr_ctrl,
  input  logic        wr_ctrl_rdy,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] write_address,
  output logic [31:0] ts_seconds,
  output logic [31:0] ts_nanoseconds,
  output logic [31:0] ctrl_out,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count,
  output logic [31:0] trunc_count,
  output logic [31:0] err_count
);
  import tcpdump_pkg::*;

  localparam logic [31:0] MAX_WORDS = 32'(MAX_PKT_WORDS);
  localparam logic [31:0] MAX_LEN   = 32'(MAX_PKT_WORDS * 4);
  localparam logic [31:0] DEPTH     = 32'(FIFO_DEPTH);

  cap_state_t  r_state, w_nextState;
  pkt_desc_t   r_desc;
  logic        r_wrCtrl, r_fifoWrreq, r_trunc, r_err;
  logic [31:0] r_fifoData, r_wordCount, r_length, r_offset, r_sopSec, r_sopNs;
  logic [31:0] r_pktCount, r_dropCount, r_truncCount, r_errCount;

  logic        w_canAdmit, w_wrEn, w_startPkt, w_endPkt, w_truncBeat;
  logic        w_drop, w_announce, w_commit;
  logic [31:0] w_free, w_wordsNow, w_lenNow, w_ringAddr;

  assign w_free     = DEPTH - {23'b0, fifo_usedw};
  assign w_canAdmit = control[0] && (w_free >= MAX_WORDS) && !fifo_full;

  ring_addr_gen #(
    .RING_BASE (RING_BASE),
    .RING_SIZE (RING_SIZE)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .i_length  (r_length),
    .i_commit  (w_commit),
    .o_address (w_ringAddr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next state and per-beat strobes; packet length is formed on the EOP beat.
  always_comb begin
    w_nextState = r_state;
    w_wrEn      = 1'b0;
    w_startPkt  = 1'b0;
    w_endPkt    = 1'b0;
    w_truncBeat = 1'b0;
    w_drop      = 1'b0;
    w_announce  = 1'b0;
    w_commit    = 1'b0;
    w_wordsNow  = 32'd1;
    w_lenNow    = '0;
    case (r_state)
      IDLE: begin
        if (st_valid && st_sop) begin
          if (w_canAdmit) begin
            w_startPkt = 1'b1;
            w_wrEn     = 1'b1;
            if (st_eop) begin
              w_endPkt    = 1'b1;
              w_nextState = ANNOUNCE;
            end else begin
              w_nextState = CAPTURE;
            end
          end else begin
            w_drop = 1'b1;
            if (!st_eop) w_nextState = DROP;
          end
        end
      end
      CAPTURE: begin
        if (st_valid) begin
          if (r_wordCount < MAX_WORDS) w_wrEn = 1'b1;
          else                         w_truncBeat = 1'b1;
          if (st_eop) begin
            w_endPkt    = 1'b1;
            w_nextState = ANNOUNCE;
          end
        end
      end
      DROP: begin
        if (st_valid && st_eop) w_nextState = IDLE;
      end
      ANNOUNCE: begin
        w_announce  = 1'b1;
        w_nextState = WAIT_DONE;
        if (st_valid && st_sop) w_drop = 1'b1;
      end
      WAIT_DONE: begin
        if (st_valid && st_sop) w_drop = 1'b1;
        if (wr_ctrl_rdy && !r_wrCtrl) begin
          w_commit    = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
    if (r_state == CAPTURE) w_wordsNow = r_wordCount + {31'b0, w_wrEn};
    if ((r_state == CAPTURE) && (r_trunc || w_truncBeat)) w_lenNow = MAX_LEN;
    else w_lenNow = (w_wordsNow << 2) - {30'b0, st_empty};
  end

  // FIFO write path, per-packet bookkeeping, descriptor and statistics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrCtrl      <= 1'b0;
      r_fifoWrreq   <= 1'b0;
      r_fifoData    <= '0;
      r_wordCount   <= '0;
      r_trunc       <= 1'b0;
      r_err         <= 1'b0;
      r_length      <= '0;
      r_offset      <= '0;
      r_sopSec      <= '0;
      r_sopNs       <= '0;
      r_desc        <= '0;
      r_desc.address <= RING_BASE;
      r_pktCount    <= '0;
      r_dropCount   <= '0;
      r_truncCount  <= '0;
      r_errCount    <= '0;
    end else begin
      r_wrCtrl    <= 1'b0;
      r_fifoWrreq <= w_wrEn;
      if (w_wrEn) r_fifoData <= st_data;
      if (w_startPkt) begin
        r_sopSec    <= seconds;
        r_sopNs     <= nanoseconds;
        r_wordCount <= 32'd1;
        r_trunc     <= 1'b0;
      end else begin
        if (w_wrEn)      r_wordCount <= r_wordCount + 32'd1;
        if (w_truncBeat) r_trunc     <= 1'b1;
      end
      if (w_endPkt) begin
        r_length <= w_lenNow;
        r_err    <= st_error;
      end
      if (w_announce) begin
        r_wrCtrl        <= 1'b1;
        r_desc.pktBegin <= r_offset;
        r_desc.pktEnd   <= r_offset + r_length;
        r_desc.address  <= w_ringAddr;
        r_desc.tsSec    <= r_sopSec;
        r_desc.tsNs     <= r_sopNs;
        r_desc.ctrl     <= control;
        r_offset        <= r_offset + r_length;
        r_pktCount      <= r_pktCount + 32'd1;
        if (r_err)   r_errCount   <= r_errCount + 32'd1;
        if (r_trunc) r_truncCount <= r_truncCount + 32'd1;
      end
      if (w_drop) r_dropCount <= r_dropCount + 32'd1;
    end
  end

  assign st_ready       = 1'b1;
  assign fifo_data      = r_fifoData;
  assign fifo_wrreq     = r_fifoWrreq;
  assign wr_ctrl        = r_wrCtrl;
  assign pkt_begin      = r_desc.pktBegin;
  assign pkt_end        = r_desc.pktEnd;
  assign write_address  = r_desc.address;
  assign ts_seconds     = r_desc.tsSec;
  assign ts_nanoseconds = r_desc.tsNs;
  assign ctrl_out       = r_desc.ctrl;
  assign pkt_count      = r_pktCount;
  assign drop_count     = r_dropCount;
  assign trunc_count    = r_truncCount;
  assign err_count      = r_errCount;

endmodule

// File: tb/tb_pkt_capture.sv
// Directed bench for pkt_capture: small ring (2048 B at 0x1000) so wrap is reachable.
module tb_pkt_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] st_data;
  logic        st_valid, st_sop, st_eop, st_error;
  logic [1:0]  st_empty;
  logic        st_ready;
  logic [31:0] control, seconds, nanoseconds;
  logic [31:0] fifo_data;
  logic        fifo_wrreq;
  logic [8:0]  fifo_usedw;
  logic        fifo_full;
  logic        wr_ctrl, wr_ctrl_rdy;
  logic [31:0] pkt_begin, pkt_end, write_address, ts_seconds, ts_nanoseconds, ctrl_out;
  logic [31:0] pkt_count, drop_count, trunc_count, err_count;

  int          passCount = 0;
  int          checkCount = 0;
  int          wrCount = 0;
  int          wrCtrlCount = 0;
  logic [31:0] lastData = '0;

  pkt_capture #(
    .RING_BASE     (32'h0000_1000),
    .RING_SIZE     (32'd2048),
    .MAX_PKT_WORDS (380),
    .FIFO_DEPTH    (512)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_sop         (st_sop),
    .st_eop         (st_eop),
    .st_empty       (st_empty),
    .st_error       (st_error),
    .st_ready       (st_ready),
    .control        (control),
    .seconds        (seconds),
    .nanoseconds    (nanoseconds),
    .fifo_data      (fifo_data),
    .fifo_wrreq     (fifo_wrreq),
    .fifo_usedw     (fifo_usedw),
    .fifo_full      (fifo_full),
    .wr_ctrl        (wr_ctrl),
    .wr_ctrl_rdy    (wr_ctrl_rdy),
    .pkt_begin      (pkt_begin),
    .pkt_end        (pkt_end),
    .write_address  (write_address),
    .ts_seconds     (ts_seconds),
    .ts_nanoseconds (ts_nanoseconds),
    .ctrl_out       (ctrl_out),
    .pkt_count      (pkt_count),
    .drop_count     (drop_count),
    .trunc_count    (trunc_count),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  // Count FIFO writes and writer start pulses as the FIFO/writer would see them.
  always @(negedge clk) begin
    if (fifo_wrreq === 1'b1) begin
      wrCount++;
      lastData = fifo_data;
    end
    if (wr_ctrl === 1'b1) wrCtrlCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // Drive one packet of back-to-back beats; SOP beat carries a distinctive timestamp.
  task automatic applyStimulus(input int nWords, input logic [1:0] empty, input logic err, input logic [31:0] seed);
    for (int i = 0; i < nWords; i++) begin
      @(negedge clk);
      st_valid    = 1'b1;
      st_data     = seed + 32'(i);
      st_sop      = (i == 0);
      st_eop      = (i == nWords - 1);
      st_empty    = (i == nWords - 1) ? empty : 2'd0;
      st_error    = (i == nWords - 1) ? err : 1'b0;
      seconds     = (i == 0) ? (seed ^ 32'h5A5A_0000) : 32'(i);
      nanoseconds = (i == 0) ? (seed + 32'd7) : 32'(i + 100);
    end
    @(negedge clk);
    st_valid = 1'b0;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
    st_empty = 2'd0;
    st_error = 1'b0;
  endtask

  // Wait (bounded) for the wr_ctrl pulse, then check the descriptor it carries.
  task automatic checkPacket(input string tag, input int expWords, input logic [31:0] expBegin,
                             input logic [31:0] expEnd, input logic [31:0] expAddr);
    int cycles = 0;
    while (wr_ctrl !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " wr_ctrl"}, {31'b0, wr_ctrl}, 32'd1);
    checkOutput({tag, " wrreq count"}, 32'(wrCount), 32'(expWords));
    checkOutput({tag, " pkt_begin"}, pkt_begin, expBegin);
    checkOutput({tag, " pkt_end"}, pkt_end, expEnd);
    checkOutput({tag, " write_address"}, write_address, expAddr);
  endtask

  task automatic pulseDone();
    @(negedge clk);
    wr_ctrl_rdy = 1'b1;
    @(negedge clk);
    wr_ctrl_rdy = 1'b0;
  endtask

  task automatic clearCounts();
    @(negedge clk);
    wrCount     = 0;
    wrCtrlCount = 0;
  endtask

  initial begin
    reset = 1'b0; st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    st_empty = 2'd0; st_error = 1'b0; control = 32'd5; seconds = '0; nanoseconds = '0;
    fifo_usedw = 9'd0; fifo_full = 1'b0; wr_ctrl_rdy = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset st_ready", {31'b0, st_ready}, 32'd1);
    checkOutput("reset fifo_wrreq", {31'b0, fifo_wrreq}, 32'd0);
    checkOutput("reset wr_ctrl", {31'b0, wr_ctrl}, 32'd0);
    checkOutput("reset write_address", write_address, 32'h0000_1000);
    checkOutput("reset pkt_end", pkt_end, 32'd0);
    checkOutput("reset pkt_count", pkt_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 64-byte packet at the ring base
    clearCounts();
    applyStimulus(16, 2'd0, 1'b0, 32'hA000_0000);
    checkPacket("p1", 16, 32'd0, 32'd64, 32'h0000_1000);
    checkOutput("p1 last word", lastData, 32'hA000_000F);
    checkOutput("p1 ts_seconds", ts_seconds, 32'hFA5A_0000);
    checkOutput("p1 ts_nanoseconds", ts_nanoseconds, 32'hA000_0007);
    checkOutput("p1 ctrl_out", ctrl_out, 32'd5);
    checkOutput("p1 pkt_count", pkt_count, 32'd1);
    pulseDone();
    checkOutput("p1 wr_ctrl pulses", 32'(wrCtrlCount), 32'd1);

    // 61-byte then 100-byte packets: records of 80 and 128 bytes
    clearCounts();
    applyStimulus(16, 2'd3, 1'b0, 32'hB000_0000);
    checkPacket("p2", 16, 32'd64, 32'd125, 32'h0000_1050);
    pulseDone();
    clearCounts();
    applyStimulus(25, 2'd0, 1'b0, 32'hC000_0000);
    checkPacket("p3", 25, 32'd125, 32'd225, 32'h0000_10A0);

    // done in the pulse cycle is ignored, so a following SOP lands in WAIT_DONE and is dropped
    wr_ctrl_rdy = 1'b1;
    @(negedge clk);
    wr_ctrl_rdy = 1'b0;
    clearCounts();
    applyStimulus(4, 2'd0, 1'b0, 32'hD000_0000);
    repeat (3) @(negedge clk);
    checkOutput("wait-drop drop_count", drop_count, 32'd1);
    checkOutput("wait-drop wrreq count", 32'(wrCount), 32'd0);
    checkOutput("wait-drop wr_ctrl count", 32'(wrCtrlCount), 32'd0);
    checkOutput("wait-drop pkt_begin held", pkt_begin, 32'd125);
    checkOutput("wait-drop pkt_end held", pkt_end, 32'd225);
    pulseDone();

    // admission refusals: FIFO too full (200, then boundary 133) and capture disabled
    fifo_usedw = 9'd200;
    clearCounts();
    applyStimulus(8, 2'd0, 1'b0, 32'hE000_0000);
    repeat (3) @(negedge clk);
    checkOutput("usedw200 drop_count", drop_count, 32'd2);
    checkOutput("usedw200 wrreq count", 32'(wrCount), 32'd0);
    fifo_usedw = 9'd133;
    applyStimulus(3, 2'd0, 1'b0, 32'hE100_0000);
    repeat (3) @(negedge clk);
    checkOutput("usedw133 drop_count", drop_count, 32'd3);
    fifo_usedw = 9'd0;
    control = 32'd0;
    applyStimulus(2, 2'd0, 1'b0, 32'hE200_0000);
    repeat (3) @(negedge clk);
    checkOutput("disabled drop_count", drop_count, 32'd4);
    checkOutput("refused wrreq count", 32'(wrCount), 32'd0);
    checkOutput("refused wr_ctrl count", 32'(wrCtrlCount), 32'd0);
    control = 32'd5;

    // admitted again with an empty FIFO
    clearCounts();
    applyStimulus(16, 2'd0, 1'b0, 32'hF000_0000);
    checkPacket("p4", 16, 32'd225, 32'd289, 32'h0000_1120);
    checkOutput("p4 ts_seconds", ts_seconds, 32'hAA5A_0000);
    checkOutput("p4 err_count", err_count, 32'd0);
    pulseDone();

    // 400-word errored packet admitted at the usedw boundary: truncated to 1520 bytes
    fifo_usedw = 9'd132;
    clearCounts();
    applyStimulus(400, 2'd2, 1'b1, 32'h1000_0000);
    fifo_usedw = 9'd0;
    checkPacket("p5", 380, 32'd289, 32'd1809, 32'h0000_1170);
    checkOutput("p5 last word", lastData, 32'h1000_017B);
    checkOutput("p5 trunc_count", trunc_count, 32'd1);
    checkOutput("p5 err_count", err_count, 32'd1);
    pulseDone();

    // 80-byte packet brings the pointer to base+2000; the next 64-byte record wraps
    clearCounts();
    applyStimulus(20, 2'd0, 1'b0, 32'h2000_0000);
    checkPacket("p6", 20, 32'd1809, 32'd1889, 32'h0000_1770);
    pulseDone();
    clearCounts();
    applyStimulus(16, 2'd0, 1'b0, 32'h3000_0000);
    checkPacket("p7 wrap", 16, 32'd1889, 32'd1953, 32'h0000_1000);
    pulseDone();

    // single-beat packet (SOP and EOP together) placed after the wrapped record
    clearCounts();
    applyStimulus(1, 2'd0, 1'b0, 32'h4000_0000);
    checkPacket("p8", 1, 32'd1953, 32'd1957, 32'h0000_1050);
    checkOutput("p8 pkt_count", pkt_count, 32'd8);
    checkOutput("p8 trunc_count", trunc_count, 32'd1);
    checkOutput("p8 drop_count", drop_count, 32'd4);
    pulseDone();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
